// File: rtl/nand_cmd_sequencer_if.sv
// Request, Avalon-MM master, byte-stream and completion signals of nand_cmd_sequencer.
// master = the sequencer side, slave = the surrounding system (NAND slave, requester, consumer).
interface nand_cmd_sequencer_if #(
  parameter int CNT_W = 12
);
  // Handshakes (req_*, out_*): a transfer happens on a rising edge where valid and
  // ready are both high; the producer holds its payload stable while valid && !ready.
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_cmd;
  logic [CNT_W-1:0] req_count;

  logic [1:0]       avm_address;
  logic             avm_read;
  logic             avm_write;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata;

  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;

  logic             done;
  logic             timeout;
  logic [7:0]       last_status;
  logic [3:0]       dbg_state;

  modport master (
    input  req_valid, req_cmd, req_count, avm_readdata, out_ready,
    output req_ready, avm_address, avm_read, avm_write, avm_writedata,
    output out_valid, out_data, done, timeout, last_status, dbg_state
  );

  modport slave (
    output req_valid, req_cmd, req_count, avm_readdata, out_ready,
    input  req_ready, avm_address, avm_read, avm_write, avm_writedata,
    input  out_valid, out_data, done, timeout, last_status, dbg_state
  );
endinterface

// File: rtl/nand_cmd_sequencer.sv
// Turns one (opcode, byte count) request into the CMD write / status poll / DATA read
// sequence against the nand_avalon slave, streaming the data bytes out.
module nand_cmd_sequencer #(
  parameter int POLL_TIMEOUT = 65535,
  parameter int CNT_W        = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nand_cmd_sequencer_if.master bus
);

  localparam int PW = (POLL_TIMEOUT < 2) ? 1 : $clog2(POLL_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    CMD_SETUP    = 4'd1,
    CMD_STROBE   = 4'd2,
    POLL1_SETUP  = 4'd3,
    POLL1_STROBE = 4'd4,
    DATA_WAIT    = 4'd5,
    DATA_SETUP   = 4'd6,
    DATA_STROBE  = 4'd7,
    DATA_OUT     = 4'd8,
    POLL2_SETUP  = 4'd9,
    POLL2_STROBE = 4'd10,
    FINISH       = 4'd11
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] byte_cnt;
  logic [PW-1:0]    poll_cnt;

  logic             req_ready_q;
  logic [1:0]       avm_address_q;
  logic             avm_read_q;
  logic             avm_write_q;
  logic [31:0]      avm_writedata_q;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             done_q;
  logic             timeout_q;
  logic [7:0]       last_status_q;

  // Controller idle (bit0 clear) and ready (bit1 set) together end a poll phase.
  logic             status_ok;
  logic             poll_expired;
  logic [CNT_W-1:0] byte_nxt;
  logic             unused_readdata;

  assign status_ok       = (bus.avm_readdata[1:0] == 2'b10);
  assign poll_expired    = (poll_cnt == POLL_LAST);
  assign byte_nxt        = byte_cnt + CNT_W'(1);
  assign unused_readdata = ^bus.avm_readdata[31:8];

  assign bus.req_ready     = req_ready_q;
  assign bus.avm_address   = avm_address_q;
  assign bus.avm_read      = avm_read_q;
  assign bus.avm_write     = avm_write_q;
  assign bus.avm_writedata = avm_writedata_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.done          = done_q;
  assign bus.timeout       = timeout_q;
  assign bus.last_status   = last_status_q;
  assign bus.dbg_state     = state;

  // Outputs are registered alongside the state: each branch programs the bus
  // values that belong to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      count_q         <= '0;
      byte_cnt        <= '0;
      poll_cnt        <= '0;
      req_ready_q     <= 1'b0;
      avm_address_q   <= 2'd0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= 32'h0;
      out_valid_q     <= 1'b0;
      out_data_q      <= 8'h00;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      last_status_q   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q     <= 1'b0;
            count_q         <= bus.req_count;
            byte_cnt        <= '0;
            poll_cnt        <= '0;
            avm_address_q   <= ADDR_CMD;
            avm_writedata_q <= {24'h0, bus.req_cmd};
            state           <= CMD_SETUP;
          end
        end

        CMD_SETUP: begin
          avm_write_q <= 1'b1;
          state       <= CMD_STROBE;
        end

        CMD_STROBE: begin
          avm_write_q   <= 1'b0;
          avm_address_q <= ADDR_STATUS;
          poll_cnt      <= '0;
          state         <= POLL1_SETUP;
        end

        POLL1_SETUP: begin
          avm_read_q <= 1'b1;
          state      <= POLL1_STROBE;
        end

        POLL1_STROBE: begin
          avm_read_q <= 1'b0;
          if (status_ok) begin
            if (count_q != '0) begin
              avm_address_q <= ADDR_DATA;
              state         <= DATA_SETUP;
            end else begin
              poll_cnt <= '0;
              state    <= POLL2_SETUP;
            end
          end else if (poll_expired) begin
            // Give up: the data and final-poll phases are skipped entirely.
            last_status_q <= bus.avm_readdata[7:0];
            timeout_q     <= 1'b1;
            done_q        <= 1'b1;
            state         <= FINISH;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
            state    <= POLL1_SETUP;
          end
        end

        DATA_SETUP: begin
          avm_read_q <= 1'b1;
          state      <= DATA_STROBE;
        end

        DATA_STROBE: begin
          avm_read_q  <= 1'b0;
          out_data_q  <= bus.avm_readdata[7:0];
          out_valid_q <= 1'b1;
          state       <= DATA_OUT;
        end

        // The next DATA_REG read waits here until the consumer takes the byte.
        DATA_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            byte_cnt    <= byte_nxt;
            if (byte_nxt < count_q) begin
              state <= DATA_SETUP;
            end else begin
              avm_address_q <= ADDR_STATUS;
              poll_cnt      <= '0;
              state         <= POLL2_SETUP;
            end
          end
        end

        POLL2_SETUP: begin
          avm_read_q <= 1'b1;
          state      <= POLL2_STROBE;
        end

        POLL2_STROBE: begin
          avm_read_q <= 1'b0;
          if (status_ok) begin
            last_status_q <= bus.avm_readdata[7:0];
            done_q        <= 1'b1;
            state         <= FINISH;
          end else if (poll_expired) begin
            last_status_q <= bus.avm_readdata[7:0];
            timeout_q     <= 1'b1;
            done_q        <= 1'b1;
            state         <= FINISH;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
            state    <= POLL2_SETUP;
          end
        end

        FINISH: begin
          done_q          <= 1'b0;
          timeout_q       <= 1'b0;
          req_ready_q     <= 1'b1;
          avm_address_q   <= 2'd0;
          avm_writedata_q <= 32'h0;
          state           <= IDLE;
        end

        // DATA_WAIT is a reserved encoding; it and any illegal code fall back to IDLE.
        default: begin
          avm_read_q  <= 1'b0;
          avm_write_q <= 1'b0;
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
          timeout_q   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// Bench for nand_cmd_sequencer: NAND slave model, stalling consumer, byte scoreboard,
// a table of request vectors and hand-written reset corner cases.
module tb_nand_cmd_sequencer;
  localparam int CNT_W   = 12;
  localparam int POLL_TO = 8;

  logic clk;
  logic rst_n;

  nand_cmd_sequencer_if #(.CNT_W(CNT_W)) bus ();

  nand_cmd_sequencer #(.POLL_TIMEOUT(POLL_TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] cmd;
    int         count;
    int         busy_n;
    logic [7:0] busy_val;
    logic [7:0] final_val;
    int         stall_at;
    int         stall_len;
    bit         rand_ready;
    bit         rand_data;
    logic       exp_to;
    logic [7:0] exp_last;
    int         exp_st_reads;
    int         exp_data_reads;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] data_q[$];
  logic [7:0] id_bytes[5];

  // slave model and monitor state
  int         st_busy_n;
  logic [7:0] st_busy_val;
  logic [7:0] st_final_val;
  int         st_idx;
  int         n_st_reads;
  int         n_data_reads;
  int         n_writes;
  logic [1:0] last_waddr;
  logic [31:0] last_wdata;
  int         rx_cnt;
  int         stall_seen;
  int         stall_at;
  int         stall_left;
  bit         rand_ready;

  logic       prev_rd, prev_wr, prev_ov, prev_or;
  logic [1:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [7:0] prev_od;

  vec_t vecs[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input int count, input int busy_n,
                              input logic [7:0] busy_val, input logic [7:0] final_val,
                              input int s_at, input int s_len, input bit rr, input bit rd,
                              input logic to, input logic [7:0] last, input int st, input int dr);
    vec_t v;
    v.cmd = cmd; v.count = count; v.busy_n = busy_n; v.busy_val = busy_val;
    v.final_val = final_val; v.stall_at = s_at; v.stall_len = s_len;
    v.rand_ready = rr; v.rand_data = rd; v.exp_to = to; v.exp_last = last;
    v.exp_st_reads = st; v.exp_data_reads = dr;
    return v;
  endfunction

  // Slave model, protocol checker and output scoreboard, all sampled mid-cycle.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rd = 0; prev_wr = 0; prev_ov = 0; prev_or = 0;
        prev_addr = 0; prev_wdata = 0; prev_od = 0;
      end else begin
        if (bus.avm_read || bus.avm_write) begin
          check("strobe_exclusive", {31'h0, bus.avm_read & bus.avm_write}, 32'h0);
          check("strobe_after_setup", {29'h0, prev_rd | prev_wr, prev_addr},
                {29'h0, 1'b0, bus.avm_address});
          if (bus.avm_write) check("wdata_held", bus.avm_writedata, prev_wdata);
        end
        if (bus.out_valid) check("no_read_while_pending", {31'h0, bus.avm_read}, 32'h0);
        if (prev_ov && !prev_or && bus.out_valid)
          check("out_data_stable", {24'h0, bus.out_data}, {24'h0, prev_od});
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: unexpected byte 0x%0h, nothing expected", bus.out_data);
          end else begin
            b = exp_q.pop_front();
            check("out_byte", {24'h0, bus.out_data}, {24'h0, b});
          end
          rx_cnt++;
        end
        if (bus.out_valid && !bus.out_ready) stall_seen++;
        if (bus.avm_write) begin
          n_writes++;
          last_waddr = bus.avm_address;
          last_wdata = bus.avm_writedata;
        end
        bus.avm_readdata = 32'h0;
        if (bus.avm_read && bus.avm_address == 2'd2) begin
          bus.avm_readdata = {24'h5A5A5A, (st_idx < st_busy_n) ? st_busy_val : st_final_val};
          st_idx++;
          n_st_reads++;
        end else if (bus.avm_read && bus.avm_address == 2'd0) begin
          b = (data_q.size() != 0) ? data_q.pop_front() : 8'hEE;
          exp_q.push_back(b);
          bus.avm_readdata = {24'hABCDEF, b};
          n_data_reads++;
        end
        prev_rd = bus.avm_read; prev_wr = bus.avm_write; prev_addr = bus.avm_address;
        prev_wdata = bus.avm_writedata; prev_ov = bus.out_valid; prev_or = bus.out_ready;
        prev_od = bus.out_data;
      end
    end
  end

  // Consumer: optional random backpressure plus one scripted stall on a chosen byte.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.out_valid && rx_cnt == stall_at && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic setup_model(input vec_t v);
    st_busy_n = v.busy_n; st_busy_val = v.busy_val; st_final_val = v.final_val;
    st_idx = 0; n_st_reads = 0; n_data_reads = 0; n_writes = 0;
    last_waddr = 0; last_wdata = 0; rx_cnt = 0; stall_seen = 0;
    stall_at = v.stall_at; stall_left = v.stall_len; rand_ready = v.rand_ready;
    data_q.delete();
    exp_q.delete();
    for (int i = 0; i < v.count; i++)
      data_q.push_back((v.rand_data || i >= 5) ? 8'($urandom_range(0, 255)) : id_bytes[i]);
  endtask

  task automatic send_req(input logic [7:0] cmd, input int count);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    bus.req_cmd   = cmd;
    bus.req_count = CNT_W'(count);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 8'($urandom_range(0, 255));
    bus.req_count = CNT_W'($urandom_range(0, 4095));
    check("req_accepted", {31'h0, got}, 32'h1);
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    setup_model(v);
    send_req(v.cmd, v.count);
    seen = 0;
    for (int k = 0; k < 30000 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    check("done_seen", {31'h0, seen}, 32'h1);
    check("timeout", {31'h0, bus.timeout}, {31'h0, v.exp_to});
    check("last_status", {24'h0, bus.last_status}, {24'h0, v.exp_last});
    check("status_reads", n_st_reads, v.exp_st_reads);
    check("data_reads", n_data_reads, v.exp_data_reads);
    check("bytes_out", rx_cnt, v.exp_data_reads);
    check("cmd_writes", n_writes, 1);
    check("cmd_write", {last_waddr, last_wdata[29:0]}, {2'd1, 22'h0, v.cmd});
    check("scoreboard_empty", exp_q.size(), 0);
    if (!v.rand_ready) check("stall_cycles", stall_seen, v.stall_len);
    @(negedge clk);
    check("done_pulse", {30'h0, bus.done, bus.timeout}, 32'h0);
    check("ready_after_done", {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    bit hit;
    id_bytes = '{8'h2C, 8'h68, 8'h04, 8'h4A, 8'hA9};
    //            cmd    cnt  busy bval   final  s_at s_len rr rd to last   st dr
    vecs[0] = mk(8'h01,    0, 2, 8'h01, 8'h02, -1,  0, 0, 0, 0, 8'h02, 4, 0);
    vecs[1] = mk(8'h03,    5, 0, 8'h01, 8'h02, -1,  0, 0, 0, 0, 8'h02, 2, 5);
    vecs[2] = mk(8'h03,    5, 0, 8'h01, 8'h02,  1, 10, 0, 0, 0, 8'h02, 2, 5);
    vecs[3] = mk(8'h00,    3, 4, 8'h00, 8'h06, -1,  0, 1, 1, 0, 8'h06, 6, 3);
    vecs[4] = mk(8'h10,    1, 7, 8'h03, 8'h02, -1,  0, 0, 1, 0, 8'h02, 9, 1);
    vecs[5] = mk(8'h05,    4, 0, 8'h01, 8'h01, -1,  0, 0, 1, 1, 8'h01, 8, 0);
    vecs[6] = mk(8'h06,    8, 1, 8'h01, 8'h42, -1,  0, 1, 1, 0, 8'h42, 3, 8);
    vecs[7] = mk(8'h19, 4095, 0, 8'h01, 8'hA2, -1,  0, 0, 1, 0, 8'hA2, 2, 4095);

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_cmd = 8'h00; bus.req_count = '0;
    bus.avm_readdata = 32'h0;
    setup_model(vecs[0]);
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.req_ready, bus.avm_read, bus.avm_write, bus.out_valid,
                          bus.done, bus.timeout, bus.avm_address, bus.out_data,
                          bus.last_status, bus.dbg_state},
          32'h0);
    check("rst_wdata", bus.avm_writedata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);

    // Reset asserted in the middle of the CMD_REG write strobe.
    send_req(8'h01, 0);
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (bus.avm_write) hit = 1;
    end
    check("cmd_strobe_reached", {31'h0, hit}, 32'h1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", {bus.req_ready, bus.avm_read, bus.avm_write,
                                      bus.out_valid, bus.done, bus.timeout, bus.dbg_state},
             32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_low_at_release", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    check("ready_edge_after_release", {31'h0, bus.req_ready}, 32'h1);

    // Reset while a data byte is held back by the consumer: the byte is dropped.
    setup_model(vecs[1]);
    stall_at = 0; stall_left = 1000;
    send_req(8'h03, 5);
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (bus.out_valid) hit = 1;
    end
    check("byte_pending", {31'h0, hit}, 32'h1);
    #1 rst_n = 1'b0;
    #1 check("pending_byte_dropped", {23'h0, bus.out_valid, bus.out_data}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_left = 0;
    repeat (2) @(negedge clk);
    check("idle_after_drop", {27'h0, bus.req_ready, bus.dbg_state}, 32'h10);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
